// File: rtl/gpio_pwm_pkg.sv
// rtl/gpio_pwm_pkg.sv - shared mode constants and channel state encoding for the PWM block
package gpio_pwm_pkg;

    localparam logic [1:0] PWM_OFF      = 2'd0;
    localparam logic [1:0] PWM_ONESHOT  = 2'd1;
    localparam logic [1:0] PWM_CONT     = 2'd2;
    localparam logic [1:0] PWM_CONT_INV = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/gpio_pwm_chan.sv
// rtl/gpio_pwm_chan.sv - one PWM channel: input shadow, high/low FSM, registered pin
module gpio_pwm_chan
    import gpio_pwm_pkg::*;
#(
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [1:0]          mode,
    input  logic                start,
    input  logic [CNT_BITS-1:0] hout,
    input  logic [CNT_BITS-1:0] lout,
    output logic                pin,
    output logic                busy,
    output logic                done
);

    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    logic [1:0]          mode_p1_q;
    logic                start_p1_q;
    logic [CNT_BITS-1:0] hout_p1_q, lout_p1_q;

    pwm_state_e          state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_BITS-1:0] h_act_q, h_act_d;
    logic [CNT_BITS-1:0] l_act_q, l_act_d;
    logic                armed_q, armed_d;
    logic                inv_q, inv_d;
    logic                pin_q, pin_d;
    logic                done_q, done_d;
    logic                load;
    logic                level;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_act_d = h_act_q;
        l_act_d = l_act_q;
        armed_d = armed_q;
        inv_d   = inv_q;
        done_d  = 1'b0;
        load    = 1'b0;
        level   = 1'b0;
        pin_d   = 1'b0;

        if (mode_p1_q == PWM_OFF) begin
            state_d = IDLE;
            armed_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mode_p1_q == PWM_ONESHOT) begin
                        if (armed_q && tick) begin
                            load = 1'b1;
                        end else if (start_p1_q) begin
                            armed_d = 1'b1;
                        end
                    end else if (tick) begin
                        load = 1'b1;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        if (cnt_q == h_act_q - CNT_ONE) begin
                            state_d = LOW;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                LOW: begin
                    if (tick) begin
                        if (l_act_q == '0 || cnt_q == l_act_q - CNT_ONE) begin
                            done_d = 1'b1;
                            if (mode_p1_q == PWM_ONESHOT) begin
                                state_d = IDLE;
                                cnt_d   = '0;
                            end else begin
                                load = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // A zero high count skips HIGH so the pin never glitches high.
            if (load) begin
                h_act_d = hout_p1_q;
                l_act_d = lout_p1_q;
                cnt_d   = '0;
                armed_d = 1'b0;
                inv_d   = (mode_p1_q == PWM_CONT_INV);
                state_d = (hout_p1_q == '0) ? LOW : HIGH;
            end
        end

        // A zero low count shows its single LOW tick as high (100% duty).
        level = (state_d == HIGH) ||
                (state_d == LOW && l_act_d == '0 && h_act_d != '0);
        pin_d = (state_d == IDLE) ? (mode_p1_q == PWM_CONT_INV) : (level ^ inv_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_p1_q  <= PWM_OFF;
            start_p1_q <= 1'b0;
            hout_p1_q  <= '0;
            lout_p1_q  <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            h_act_q    <= '0;
            l_act_q    <= '0;
            armed_q    <= 1'b0;
            inv_q      <= 1'b0;
            pin_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            mode_p1_q  <= mode;
            start_p1_q <= start;
            hout_p1_q  <= hout;
            lout_p1_q  <= lout;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            h_act_q    <= h_act_d;
            l_act_q    <= l_act_d;
            armed_q    <= armed_d;
            inv_q      <= inv_d;
            pin_q      <= pin_d;
            done_q     <= done_d;
        end
    end

    assign pin  = pin_q;
    assign done = done_q;
    assign busy = (state_q != IDLE) || armed_q;

endmodule

// File: rtl/gpio_pwm_multi.sv
// rtl/gpio_pwm_multi.sv - shared prescaler driving CH_NUM independent PWM channels
module gpio_pwm_multi
    import gpio_pwm_pkg::*;
#(
    parameter int CH_NUM   = 4,
    parameter int CNT_BITS = 16,
    parameter int PRE_BITS = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PRE_BITS-1:0]        pwm_prescale,
    input  logic [CH_NUM*CNT_BITS-1:0] pwm_hout,
    input  logic [CH_NUM*CNT_BITS-1:0] pwm_lout,
    input  logic [CH_NUM*2-1:0]        pwm_ctrl,
    input  logic [CH_NUM-1:0]          pwm_start,
    output logic [CH_NUM-1:0]          pwm_pin,
    output logic [CH_NUM-1:0]          pwm_busy,
    output logic [CH_NUM-1:0]          pwm_done
);

    localparam logic [PRE_BITS-1:0] PRE_ONE = {{(PRE_BITS-1){1'b0}}, 1'b1};

    logic [PRE_BITS-1:0] prescale_p1_q;
    logic [PRE_BITS-1:0] pre_cnt_q, pre_cnt_d;
    logic                tick;

    // >= rather than == so a lowered divisor wraps at once instead of rolling over.
    always_comb begin
        tick      = (pre_cnt_q >= prescale_p1_q);
        pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_p1_q <= '0;
            pre_cnt_q     <= '0;
        end else begin
            prescale_p1_q <= pwm_prescale;
            pre_cnt_q     <= pre_cnt_d;
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
        gpio_pwm_chan #(
            .CNT_BITS (CNT_BITS)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .mode  (pwm_ctrl[i*2 +: 2]),
            .start (pwm_start[i]),
            .hout  (pwm_hout[i*CNT_BITS +: CNT_BITS]),
            .lout  (pwm_lout[i*CNT_BITS +: CNT_BITS]),
            .pin   (pwm_pin[i]),
            .busy  (pwm_busy[i]),
            .done  (pwm_done[i])
        );
    end

endmodule

// File: doc/gpio_pwm_multi.md
Name: gpio_pwm_multi

Overview:
Multi-channel, parametrised PWM generator for the GPIO design. One shared programmable prescaler drives CH_NUM independent PWM channels. Each channel has its own high/low tick counts, mode (off, one-shot, continuous, continuous-inverted), a start strobe and busy/done status. New high/low values are shadowed and applied only at period boundaries, so updates are glitch-free. The block sits between the GPIO control register bank and the pin mux.

Parameters:
CH_NUM, 4, number of PWM channels
CNT_BITS, 16, width of per-channel high/low tick counts
PRE_BITS, 20, width of shared prescale divisor

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pwm_prescale  in  PRE_BITS  tick every (pwm_prescale+1) clocks; 0 = tick every clock
pwm_hout  in  CH_NUM*CNT_BITS  per-channel high-phase ticks, channel i at [i*CNT_BITS +: CNT_BITS]
pwm_lout  in  CH_NUM*CNT_BITS  per-channel low-phase ticks, same packing
pwm_ctrl  in  CH_NUM*2  per-channel mode: 0 off, 1 one-shot, 2 continuous, 3 continuous inverted
pwm_start  in  CH_NUM  one-clock strobe; arms a one-shot channel
pwm_pin  out  CH_NUM  registered PWM outputs
pwm_busy  out  CH_NUM  channel is not IDLE
pwm_done  out  CH_NUM  one-clock pulse at end of each completed period

Behaviour:
- Reset: all outputs 0, all channels IDLE, prescale counter 0, shadow and active registers 0.
- Input registers: all inputs are registered once (_p1) before use, adding 1 clk of latency.
- Prescaler: pre_cnt counts clocks. When pre_cnt >= pre_stop_p1, it asserts tick for 1 clk and pre_cnt wraps to 0; otherwise pre_cnt increments.
  - The >= compare means that lowering the prescale value mid-count wraps on the next clock with no long stall.
  - prescale=0 gives tick on every clock.
- Per-channel FSM with states IDLE, HIGH, LOW and a tick counter cnt[CNT_BITS-1:0]. All state changes happen only on tick, except mode-0 clearing.
  - Load event: on entry to HIGH, h_act<=hout_p1 and l_act<=lout_p1, and cnt<=0.
  - Period: h_act ticks high followed by l_act ticks low.
- IDLE:
  - Mode 2/3: load and go to HIGH on the next tick.
  - Mode 1: pwm_start_p1 sets an armed flag. While armed, load and go to HIGH on the next tick, clearing armed.
  - Mode 0: stay in IDLE.
- HIGH: on each tick cnt++. When cnt==h_act-1, go to LOW with cnt<=0. If h_act==0 on entry, go to LOW immediately (0% duty).
- LOW: on each tick cnt++. When cnt==l_act-1, the period ends:
  - pwm_done pulses for 1 clk.
  - Mode 1: go to IDLE.
  - Mode 2/3: reload and go to HIGH.
  - If l_act==0, the period ends on the first LOW tick with the output held high (100% duty).
  - If h_act==l_act==0, the output stays low and done pulses every tick.
- Internal level is 1 in HIGH and 0 in IDLE/LOW. pwm_pin <= level XOR (mode==3), registered, so mode 3 idles high.
- pwm_busy = (state != IDLE) || armed.
- Mode 0, at any time: the next clk forces IDLE, clears armed and cnt, and drives pin 0.
- Switching between non-zero modes takes effect at the next period end; active values are not reloaded mid-period.
- pwm_start while busy is ignored. pwm_start in modes 0/2/3 is ignored.
- hout/lout changes mid-period have no effect until the next load event.
- Asynchronous reset mid-period returns the channel to its reset state immediately.
- Counter widths are fixed at CNT_BITS with no overflow: cnt never exceeds the active value minus 1.

Decomposition:
- Shared package gpio_pwm_pkg: mode constants (PWM_OFF=2'd0, PWM_ONESHOT=2'd1, PWM_CONT=2'd2, PWM_CONT_INV=2'd3) and the FSM state encoding (IDLE, HIGH, LOW).
- Sub-module gpio_pwm_chan: one channel's FSM, shadow registers and output flop, instantiated CH_NUM times via generate.
- The prescaler stays in the top level.

Test Plan:
- Continuous timing: prescale=0, ch0 mode 2, h=3, l=2 -> steady-state pin pattern 1,1,1,0,0 repeating (period 5 clk); done pulses once per 5 clk.
- Prescaler: prescale=9, ch1 mode 2, h=1, l=1 -> pin toggles every 10 clk (20 clk period).
- One-shot: prescale=0, ch2 mode 1, h=2, l=3, single start pulse:
  - pin high for exactly 2 clk, then low;
  - done pulses once after 3 low ticks, then busy=0;
  - a second start while busy -> no extra pulse.
- Glitch-free update: ch0 mode 2, h=4, l=4; change to h=1, l=7 mid-HIGH -> current period completes as 4/4; next period is 1/7.
- Edge duties and inversion:
  - h=0 -> pin constant 0, done each period;
  - l=0 -> pin constant 1;
  - mode 3 with h=2, l=6 -> pin low 2 ticks, high 6; pin is high while idle.
- Abort and reset: mode set to 0 mid-HIGH -> pin 0 and busy 0 within 2 clk; reset asserted mid-period -> all pins, busy and done go to 0 immediately.
